user_obi_mux: RTL and testbench
===============================

Name: user_obi_mux

Overview:
- N-to-1 OBI arbiter for the user domain's outbound manager path: merges several user managers (CNN accelerator plus future DMA/engines) onto the single user manager port toward the Croc crossbar.
- Functionally the reverse of the subordinate demux: it arbitrates requests onto one port, tracks outstanding transactions in order, and routes each response back to the originating manager.
- OBI responses are strictly in order; no ID remapping is done.

Parameters:
- NumMgr, 2, number of upstream managers (>=2).
- AddrWidth, 32, OBI address width.
- DataWidth, 32, OBI data width; byte-enable width is DataWidth/8.
- IdWidth, 1, OBI aid/rid width, passed through unchanged.
- MaxTrans, 2, maximum outstanding transactions on the downstream port (>=1).

Ports:
- clk_i  in  1  clock; single clock domain.
- rst_i  in  1  reset, synchronous, active-high.
- mgr_req_i  in  NumMgr  per-manager request.
- mgr_gnt_o  out  NumMgr  per-manager grant.
- mgr_addr_i  in  NumMgr*AddrWidth  per-manager address.
- mgr_we_i  in  NumMgr  per-manager write enable.
- mgr_be_i  in  NumMgr*DataWidth/8  per-manager byte enables.
- mgr_wdata_i  in  NumMgr*DataWidth  per-manager write data.
- mgr_aid_i  in  NumMgr*IdWidth  per-manager transaction ID.
- mgr_rvalid_o  out  NumMgr  per-manager response valid.
- mgr_rdata_o  out  DataWidth  response data, broadcast to all managers.
- mgr_rid_o  out  IdWidth  response ID, broadcast.
- mgr_err_o  out  1  response error, broadcast.
- out_req_o  out  1  downstream request.
- out_gnt_i  in  1  downstream grant.
- out_addr_o, out_we_o, out_be_o, out_wdata_o, out_aid_o  out  AddrWidth/1/DataWidth/8/DataWidth/IdWidth  downstream request payload.
- out_rvalid_i, out_rdata_i, out_rid_i, out_err_i  in  1/DataWidth/IdWidth/1  downstream response.

Behaviour:
- Reset (rst_i=1 at a clk_i edge): rr_ptr=0, lock=0, tracking FIFO empty (count=0).
  - While rst_i is high, out_req_o=0, mgr_gnt_o=0, mgr_rvalid_o=0.
  - Payload outputs are don't-care during reset; implement them as 0.
- Selection (combinational):
  - If lock=1, sel=locked_idx.
  - Otherwise sel is the first requesting manager searching from rr_ptr upward, wrapping modulo NumMgr.
- Request gating:
  - out_req_o = mgr_req_i[sel] AND (count < MaxTrans).
  - The payload outputs mirror manager sel.
- Grant: mgr_gnt_o[sel] = out_gnt_i AND out_req_o; all other grant bits are 0.
- Lock:
  - If out_req_o=1 and out_gnt_i=0, set lock=1 and locked_idx=sel next cycle.
  - Clear lock on handshake.
  - This guarantees OBI request stability: no re-arbitration while a request is pending.
- Handshake (out_req_o & out_gnt_i):
  - Push sel into the tracking FIFO (depth MaxTrans).
  - rr_ptr <= (sel+1) mod NumMgr.
  - Latency from mgr_req_i to out_req_o is 0 cycles when unlocked and not full.
- Full:
  - When count==MaxTrans, out_req_o=0 even if managers request.
  - A pop in the same cycle does not unblock the request; the request can go out the next cycle.
- Response routing (combinational):
  - mgr_rvalid_o[fifo_head] = out_rvalid_i when count>0.
  - rdata/rid/err pass through directly.
  - On out_rvalid_i, pop the FIFO.
- Simultaneous push and pop: count stays unchanged; head advances and the new entry is written at tail.
- out_rvalid_i with count==0: protocol violation. Ignored: no rvalid is forwarded and there is no state change.
- Responses never precede their grant. OBI guarantees rvalid arrives at the earliest one cycle after gnt; the FIFO does not need a bypass.
- Reset mid-transaction: outstanding entries and lock are discarded, and any late responses are ignored per the rule above.
- A manager dropping its request while lock=1 is an upstream protocol violation; the mux keeps presenting the locked request.

Test Plan:
- Single manager 0 reads addr 0x1000_0000, gnt same cycle, rvalid next cycle with rdata 0xDEADBEEF -> out_req_o high in cycle 0; mgr_gnt_o=2'b01; mgr_rvalid_o=2'b01 in cycle 1 with rdata 0xDEADBEEF; rr_ptr=1.
- Both managers request continuously with gnt always 1 (NumMgr=2) -> grants alternate 01,10,01,10 over 4 cycles.
- Manager 1 requests, out_gnt_i held 0 for 3 cycles, then manager 0 also requests -> out_addr_o stays at manager 1's address until gnt; manager 1 is granted first and manager 0 next.
- MaxTrans=2 with rvalid withheld -> after 2 handshakes out_req_o=0; one rvalid -> out_req_o reasserts the following cycle; responses go to managers in grant order (0 then 1).
- Assert rst_i with 2 outstanding, then deassert and send a spurious out_rvalid_i -> mgr_rvalid_o stays 0, count=0, and the next request is granted normally starting from manager 0.

Source files
------------

// File: rtl/user_obi_mux.sv
// user_obi_mux: N-to-1 OBI arbiter for the user manager path.
// Round-robin select, lock while ungranted, in-order response routing.
module user_obi_mux #(
    parameter int unsigned NumMgr    = 2,
    parameter int unsigned AddrWidth = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned IdWidth   = 1,
    parameter int unsigned MaxTrans  = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumMgr-1:0]               mgr_req_i,
    output logic [NumMgr-1:0]               mgr_gnt_o,
    input  logic [NumMgr*AddrWidth-1:0]     mgr_addr_i,
    input  logic [NumMgr-1:0]               mgr_we_i,
    input  logic [NumMgr*DataWidth/8-1:0]   mgr_be_i,
    input  logic [NumMgr*DataWidth-1:0]     mgr_wdata_i,
    input  logic [NumMgr*IdWidth-1:0]       mgr_aid_i,
    output logic [NumMgr-1:0]               mgr_rvalid_o,
    output logic [DataWidth-1:0]            mgr_rdata_o,
    output logic [IdWidth-1:0]              mgr_rid_o,
    output logic                            mgr_err_o,
    output logic                            out_req_o,
    input  logic                            out_gnt_i,
    output logic [AddrWidth-1:0]            out_addr_o,
    output logic                            out_we_o,
    output logic [DataWidth/8-1:0]          out_be_o,
    output logic [DataWidth-1:0]            out_wdata_o,
    output logic [IdWidth-1:0]              out_aid_o,
    input  logic                            out_rvalid_i,
    input  logic [DataWidth-1:0]            out_rdata_i,
    input  logic [IdWidth-1:0]              out_rid_i,
    input  logic                            out_err_i
);

    localparam int unsigned BeWidth = DataWidth / 8;
    localparam int unsigned IdxW    = (NumMgr > 1) ? $clog2(NumMgr) : 1;
    localparam int unsigned PtrW    = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned CntW    = $clog2(MaxTrans + 1);

    typedef logic [IdxW-1:0] idx_t;

    idx_t            rr_ptr;
    idx_t            locked_idx;
    idx_t            sel;
    idx_t            sel_rr;
    idx_t            cand;
    idx_t            nxt_ptr;
    logic            lock;
    logic            found;
    logic            full;
    logic            hs;
    logic            pop;
    logic [CntW-1:0] count;
    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    idx_t            fifo_q [MaxTrans];

    always_comb begin
        sel_rr = rr_ptr;
        cand   = rr_ptr;
        found  = 1'b0;
        for (int unsigned i = 0; i < NumMgr; i++) begin
            cand = idx_t'((32'(rr_ptr) + i) % NumMgr);
            if (!found && mgr_req_i[cand]) begin
                found  = 1'b1;
                sel_rr = cand;
            end
        end
    end

    assign sel     = lock ? locked_idx : sel_rr;
    assign full    = (count == CntW'(MaxTrans));
    assign nxt_ptr = (sel == idx_t'(NumMgr - 1)) ? '0 : sel + 1'b1;

    // A locked request keeps being presented until it is granted.
    assign out_req_o = !rst_i && (lock || found) && !full;
    assign hs        = out_req_o && out_gnt_i;
    assign pop       = !rst_i && out_rvalid_i && (count != '0);

    always_comb begin
        out_addr_o  = '0;
        out_we_o    = 1'b0;
        out_be_o    = '0;
        out_wdata_o = '0;
        out_aid_o   = '0;
        mgr_gnt_o   = '0;
        if (!rst_i) begin
            out_addr_o  = mgr_addr_i[32'(sel)*AddrWidth +: AddrWidth];
            out_we_o    = mgr_we_i[sel];
            out_be_o    = mgr_be_i[32'(sel)*BeWidth +: BeWidth];
            out_wdata_o = mgr_wdata_i[32'(sel)*DataWidth +: DataWidth];
            out_aid_o   = mgr_aid_i[32'(sel)*IdWidth +: IdWidth];
            mgr_gnt_o[sel] = hs;
        end
    end

    always_comb begin
        mgr_rvalid_o = '0;
        if (pop) begin
            mgr_rvalid_o[fifo_q[rd_ptr]] = 1'b1;
        end
    end

    assign mgr_rdata_o = out_rdata_i;
    assign mgr_rid_o   = out_rid_i;
    assign mgr_err_o   = out_err_i;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxTrans - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr     <= '0;
            lock       <= 1'b0;
            locked_idx <= '0;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            if (hs) begin
                lock   <= 1'b0;
                rr_ptr <= nxt_ptr;
                wr_ptr <= ptr_inc(wr_ptr);
            end else if (out_req_o) begin
                lock       <= 1'b1;
                locked_idx <= sel;
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({hs, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (hs) begin
            fifo_q[wr_ptr] <= sel;
        end
    end

endmodule

// File: tb/tb_user_obi_mux.sv
// tb_user_obi_mux: directed plan cases plus randomized traffic
// checked against a queue-based arbitration model.
module tb_user_obi_mux;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 1;
    localparam int MT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      mgr_req_i;
    logic [N-1:0]      mgr_gnt_o;
    logic [N*AW-1:0]   mgr_addr_i;
    logic [N-1:0]      mgr_we_i;
    logic [N*DW/8-1:0] mgr_be_i;
    logic [N*DW-1:0]   mgr_wdata_i;
    logic [N*IW-1:0]   mgr_aid_i;
    logic [N-1:0]      mgr_rvalid_o;
    logic [DW-1:0]     mgr_rdata_o;
    logic [IW-1:0]     mgr_rid_o;
    logic              mgr_err_o;
    logic              out_req_o;
    logic              out_gnt_i;
    logic [AW-1:0]     out_addr_o;
    logic              out_we_o;
    logic [DW/8-1:0]   out_be_o;
    logic [DW-1:0]     out_wdata_o;
    logic [IW-1:0]     out_aid_o;
    logic              out_rvalid_i;
    logic [DW-1:0]     out_rdata_i;
    logic [IW-1:0]     out_rid_i;
    logic              out_err_i;

    always #5 clk = ~clk;

    user_obi_mux #(
        .NumMgr(N), .AddrWidth(AW), .DataWidth(DW),
        .IdWidth(IW), .MaxTrans(MT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .mgr_req_i(mgr_req_i), .mgr_gnt_o(mgr_gnt_o),
        .mgr_addr_i(mgr_addr_i), .mgr_we_i(mgr_we_i),
        .mgr_be_i(mgr_be_i), .mgr_wdata_i(mgr_wdata_i),
        .mgr_aid_i(mgr_aid_i), .mgr_rvalid_o(mgr_rvalid_o),
        .mgr_rdata_o(mgr_rdata_o), .mgr_rid_o(mgr_rid_o),
        .mgr_err_o(mgr_err_o), .out_req_o(out_req_o),
        .out_gnt_i(out_gnt_i), .out_addr_o(out_addr_o),
        .out_we_o(out_we_o), .out_be_o(out_be_o),
        .out_wdata_o(out_wdata_o), .out_aid_o(out_aid_o),
        .out_rvalid_i(out_rvalid_i), .out_rdata_i(out_rdata_i),
        .out_rid_i(out_rid_i), .out_err_i(out_err_i)
    );

    logic          m_req  [N];
    logic [AW-1:0] m_addr [N];
    logic          m_we   [N];
    logic [3:0]    m_be   [N];
    logic [DW-1:0] m_wd   [N];
    logic [IW-1:0] m_aid  [N];

    always_comb begin
        mgr_req_i   = '0;
        mgr_addr_i  = '0;
        mgr_we_i    = '0;
        mgr_be_i    = '0;
        mgr_wdata_i = '0;
        mgr_aid_i   = '0;
        for (int i = 0; i < N; i++) begin
            mgr_req_i[i]          = m_req[i];
            mgr_addr_i[i*AW +: AW] = m_addr[i];
            mgr_we_i[i]           = m_we[i];
            mgr_be_i[i*4 +: 4]    = m_be[i];
            mgr_wdata_i[i*DW +: DW] = m_wd[i];
            mgr_aid_i[i*IW +: IW] = m_aid[i];
        end
    end

    int n_chk = 0;
    int n_err = 0;

    // reference model: rotating priority, pending-request hold, order queue
    int       rr;
    bit       lk;
    int       lidx;
    int       q[$];
    bit       e_req;
    bit       e_pop;
    int       e_sel;
    logic [N-1:0] e_gnt;
    logic [N-1:0] e_rv;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic settle();
        #4;
        e_sel = -1;
        if (!rst) begin
            if (lk) begin
                e_sel = lidx;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (e_sel < 0 && m_req[(rr + k) % N]) e_sel = (rr + k) % N;
                end
            end
        end
        e_req = !rst && e_sel >= 0 && q.size() < MT;
        e_gnt = '0;
        if (e_req && out_gnt_i) e_gnt[e_sel] = 1'b1;
        e_pop = !rst && out_rvalid_i && q.size() > 0;
        e_rv  = '0;
        if (e_pop) e_rv[q[0]] = 1'b1;
        chk("req", out_req_o, e_req);
        chk("gnt", mgr_gnt_o, e_gnt);
        chk("rvalid", mgr_rvalid_o, e_rv);
        chk("rdata", mgr_rdata_o, out_rdata_i);
        chk("rid", mgr_rid_o, out_rid_i);
        chk("err", mgr_err_o, out_err_i);
        if (e_req) begin
            chk("addr", out_addr_o, m_addr[e_sel]);
            chk("we", out_we_o, m_we[e_sel]);
            chk("be", out_be_o, m_be[e_sel]);
            chk("wdata", out_wdata_o, m_wd[e_sel]);
            chk("aid", out_aid_o, m_aid[e_sel]);
        end
        if (rst) chk("addr_rst", out_addr_o, 0);
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            rr = 0;
            lk = 0;
            q.delete();
        end else begin
            if (e_pop) void'(q.pop_front());
            if (e_req && out_gnt_i) begin
                q.push_back(e_sel);
                rr = (e_sel + 1) % N;
                lk = 0;
            end else if (e_req) begin
                lk   = 1;
                lidx = e_sel;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < N; i++) begin
            m_req[i]  = 1'b0;
            m_addr[i] = 32'h1000_0000 + 32'(i) * 32'h100;
            m_we[i]   = 1'b0;
            m_be[i]   = 4'hf;
            m_wd[i]   = 32'(i) + 32'h55;
            m_aid[i]  = IW'(i);
        end
        out_gnt_i    = 1'b0;
        out_rvalid_i = 1'b0;
        out_rdata_i  = '0;
        out_rid_i    = '0;
        out_err_i    = 1'b0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        settle();
        advance();
        settle();
        advance();
        rst = 1'b0;
    endtask

    logic [N-1:0] granted;
    logic [1:0]   alt [4];

    initial begin
        rr = 0;
        lk = 0;
        lidx = 0;
        reset_dut();

        // single read by manager 0
        m_req[0]  = 1'b1;
        m_addr[0] = 32'h1000_0000;
        out_gnt_i = 1'b1;
        settle();
        chk("t1_req", out_req_o, 1);
        chk("t1_gnt", mgr_gnt_o, 2'b01);
        advance();
        m_req[0]     = 1'b0;
        out_gnt_i    = 1'b0;
        out_rvalid_i = 1'b1;
        out_rdata_i  = 32'hDEAD_BEEF;
        settle();
        chk("t1_rv", mgr_rvalid_o, 2'b01);
        chk("t1_rdata", mgr_rdata_o, 32'hDEAD_BEEF);
        advance();
        out_rvalid_i = 1'b0;
        m_req[0]  = 1'b1;
        m_req[1]  = 1'b1;
        out_gnt_i = 1'b1;
        settle();
        chk("t1_rr", mgr_gnt_o, 2'b10);
        advance();

        // alternating grants with continuous traffic
        reset_dut();
        alt[0] = 2'b01; alt[1] = 2'b10; alt[2] = 2'b01; alt[3] = 2'b10;
        m_req[0] = 1'b1;
        m_req[1] = 1'b1;
        out_gnt_i    = 1'b1;
        out_rvalid_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            settle();
            chk("t2_alt", mgr_gnt_o, alt[c]);
            advance();
        end

        // lock holds manager 1 against a later manager 0 request
        reset_dut();
        m_req[1]  = 1'b1;
        m_addr[1] = 32'h2000_0040;
        m_addr[0] = 32'h3000_0080;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) m_req[0] = 1'b1;
            settle();
            chk("t3_addr", out_addr_o, 32'h2000_0040);
            advance();
        end
        out_gnt_i = 1'b1;
        settle();
        chk("t3_gnt1", mgr_gnt_o, 2'b10);
        advance();
        m_req[1] = 1'b0;
        settle();
        chk("t3_gnt0", mgr_gnt_o, 2'b01);
        chk("t3_addr0", out_addr_o, 32'h3000_0080);
        advance();

        // outstanding limit and in-order routing
        reset_dut();
        m_req[0] = 1'b1;
        m_req[1] = 1'b1;
        out_gnt_i = 1'b1;
        settle(); chk("t4_g0", mgr_gnt_o, 2'b01); advance();
        settle(); chk("t4_g1", mgr_gnt_o, 2'b10); advance();
        settle(); chk("t4_full", out_req_o, 0); advance();
        out_rvalid_i = 1'b1;
        settle();
        chk("t4_rv0", mgr_rvalid_o, 2'b01);
        chk("t4_popblk", out_req_o, 0);
        advance();
        out_rvalid_i = 1'b0;
        settle(); chk("t4_reopen", out_req_o, 1); advance();
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        out_rvalid_i = 1'b1;
        settle(); chk("t4_rv1", mgr_rvalid_o, 2'b10); advance();
        settle(); chk("t4_rv2", mgr_rvalid_o, 2'b01); advance();

        // reset with outstanding traffic, then a spurious response
        reset_dut();
        m_req[0] = 1'b1;
        m_req[1] = 1'b1;
        out_gnt_i = 1'b1;
        settle(); advance();
        settle(); advance();
        rst = 1'b1;
        settle(); advance();
        rst = 1'b0;
        m_req[0] = 1'b0;
        m_req[1] = 1'b0;
        out_rvalid_i = 1'b1;
        settle(); chk("t5_spur", mgr_rvalid_o, 2'b00); advance();
        out_rvalid_i = 1'b0;
        m_req[0] = 1'b1;
        m_req[1] = 1'b1;
        settle(); chk("t5_restart", mgr_gnt_o, 2'b01); advance();

        // randomized traffic
        reset_dut();
        granted = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!m_req[i] || granted[i]) begin
                    m_req[i]  = 1'($urandom_range(0, 1));
                    m_addr[i] = $urandom;
                    m_we[i]   = 1'($urandom_range(0, 1));
                    m_be[i]   = 4'($urandom);
                    m_wd[i]   = $urandom;
                    m_aid[i]  = IW'($urandom);
                end
            end
            out_gnt_i = ($urandom_range(0, 2) != 0);
            if (q.size() > 0) out_rvalid_i = 1'($urandom_range(0, 1));
            else out_rvalid_i = ($urandom_range(0, 7) == 0);
            out_rdata_i = $urandom;
            out_rid_i   = IW'($urandom);
            out_err_i   = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 199) == 0);
            settle();
            granted = e_gnt;
            advance();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
